// File: rtl/mipi_rx_raw_unpack.sv
// MIPI CSI-2 RAW8/RAW10/RAW12 unpacker: LANES bytes per beat in, 4 pixels per beat out.
// Optional MIPI_UNPACK_STATS_EN adds per-line group and stall counters.
module mipi_rx_raw_unpack #(
   parameter int unsigned LANES     = 4,
   parameter int unsigned PIX_W     = 12,
   parameter int unsigned BUF_BYTES = 16
) (
   input  logic                 clk_i,
   input  logic                 reset_n,
   input  logic [1:0]           mode_i,
   input  logic                 sol_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [8*LANES-1:0]   in_data_i,
   input  logic                 in_eol_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [4*PIX_W-1:0]   out_pix_o,
   output logic                 err_residual_o,
   output logic                 cfg_err_o
`ifdef MIPI_UNPACK_STATS_EN
   ,
   output logic [15:0]          grp_cnt_o,
   output logic [15:0]          stall_cnt_o
`endif
);

   localparam int unsigned PW = (BUF_BYTES > 1) ? $clog2(BUF_BYTES) : 1;
   localparam int unsigned CW = $clog2(BUF_BYTES + 1);

   typedef enum logic [1:0] {StIdle, StActive, StDrain} state_e;

   state_e               state_q, state_d;
   logic [1:0]           mode_q, mode_d;
   logic [CW-1:0]        count_q, count_d;
   logic [PW-1:0]        rd_q, rd_d, wr_q, wr_d;
   logic                 in_ready_q, in_ready_d;
   logic                 out_valid_q, out_valid_d;
   logic [4*PIX_W-1:0]   out_pix_q, out_pix_d;
   logic                 err_res_q, err_res_d;
   logic                 cfg_err_q, cfg_err_d;
   logic [7:0]           mem_q [BUF_BYTES];

   logic [1:0]           mode_dec, mode_eff;
   logic [PW-1:0]        rd_eff, wr_eff;
   logic                 push, pop;
   int unsigned          grp, cnt_eff, avail, nc;
   logic [7:0]           vb [6];
   logic [11:0]          px [4];

   function automatic logic [PW-1:0] wrap(input int unsigned v);
      int unsigned r;
      r = (v >= BUF_BYTES) ? v - BUF_BYTES : v;
      return PW'(r);
   endfunction

   always_comb begin
      mode_dec = (mode_i == 2'b11) ? 2'b00 : mode_i;
      mode_eff = sol_i ? mode_dec : mode_q;
      case (mode_eff)
         2'b01:   grp = 5;
         2'b10:   grp = 6;
         default: grp = 4;
      endcase

      // A start-of-line drops the old buffer; a concurrent beat lands at byte 0.
      cnt_eff = sol_i ? 0 : 32'(count_q);
      rd_eff  = sol_i ? '0 : rd_q;
      wr_eff  = sol_i ? '0 : wr_q;
      push    = in_valid_i & in_ready_q;
      avail   = cnt_eff + (push ? LANES : 0);
      pop     = (!out_valid_q || out_ready_i) && (avail >= grp);

      // Group view bypasses the incoming beat so a completing beat emits next cycle.
      for (int unsigned k = 0; k < 6; k++) begin
         if (k < cnt_eff) begin
            vb[k] = mem_q[wrap(32'(rd_eff) + k)];
         end else if (k < avail) begin
            vb[k] = in_data_i[8*(k-cnt_eff) +: 8];
         end else begin
            vb[k] = 8'h00;
         end
      end

      case (mode_eff)
         2'b01: begin
            for (int unsigned k = 0; k < 4; k++) begin
               px[k] = {2'b00, vb[k], vb[4][2*k +: 2]};
            end
         end
         2'b10: begin
            px[0] = {vb[0], vb[2][3:0]};
            px[1] = {vb[1], vb[2][7:4]};
            px[2] = {vb[3], vb[5][3:0]};
            px[3] = {vb[4], vb[5][7:4]};
         end
         default: begin
            for (int unsigned k = 0; k < 4; k++) begin
               px[k] = {4'h0, vb[k]};
            end
         end
      endcase

      out_valid_d = out_valid_q;
      out_pix_d   = out_pix_q;
      if (pop) begin
         out_valid_d = 1'b1;
         for (int unsigned k = 0; k < 4; k++) begin
            out_pix_d[k*PIX_W +: PIX_W] = PIX_W'(px[k]);
         end
      end else if (out_ready_i) begin
         out_valid_d = 1'b0;
      end

      nc        = avail - (pop ? grp : 0);
      rd_d      = wrap(32'(rd_eff) + (pop ? grp : 0));
      wr_d      = wrap(32'(wr_eff) + (push ? LANES : 0));
      state_d   = state_q;
      mode_d    = mode_q;
      err_res_d = 1'b0;
      cfg_err_d = cfg_err_q;

      case (state_q)
         StActive: begin
            if (push && in_eol_i) state_d = StDrain;
         end
         StDrain: begin
            if (32'(count_q) < grp) begin
               err_res_d = (count_q != '0);
               nc        = 0;
               rd_d      = '0;
               wr_d      = '0;
               state_d   = StIdle;
            end
         end
         default: ;
      endcase

      if (sol_i) begin
         state_d   = (push && in_eol_i) ? StDrain : StActive;
         mode_d    = mode_dec;
         err_res_d = 1'b0;
         cfg_err_d = cfg_err_q | (mode_i == 2'b11);
      end

      count_d    = CW'(nc);
      in_ready_d = (state_d == StActive) && ((BUF_BYTES - nc) >= LANES);
   end

   always_ff @(posedge clk_i or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         mode_q      <= 2'b00;
         count_q     <= '0;
         rd_q        <= '0;
         wr_q        <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_pix_q   <= '0;
         err_res_q   <= 1'b0;
         cfg_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         count_q     <= count_d;
         rd_q        <= rd_d;
         wr_q        <= wr_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_pix_q   <= out_pix_d;
         err_res_q   <= err_res_d;
         cfg_err_q   <= cfg_err_d;
      end
   end

   // Byte storage needs no reset; count gates every read.
   always_ff @(posedge clk_i) begin
      if (push) begin
         for (int unsigned j = 0; j < LANES; j++) begin
            mem_q[wrap(32'(wr_eff) + j)] <= in_data_i[8*j +: 8];
         end
      end
   end

   assign in_ready_o     = in_ready_q;
   assign out_valid_o    = out_valid_q;
   assign out_pix_o      = out_pix_q;
   assign err_residual_o = err_res_q;
   assign cfg_err_o      = cfg_err_q;

`ifdef MIPI_UNPACK_STATS_EN
   logic [15:0] grp_cnt_q, stall_cnt_q;

   always_ff @(posedge clk_i or negedge reset_n) begin
      if (!reset_n) begin
         grp_cnt_q   <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (sol_i) begin
            grp_cnt_q <= pop ? 16'd1 : 16'd0;
         end else if (pop && grp_cnt_q != 16'hFFFF) begin
            grp_cnt_q <= grp_cnt_q + 16'd1;
         end
         if (out_valid_q && !out_ready_i && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
         end
      end
   end

   assign grp_cnt_o   = grp_cnt_q;
   assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mipi_rx_raw_unpack.sv
// Directed self-checking bench for mipi_rx_raw_unpack (LANES=4, PIX_W=12, BUF_BYTES=16).
module tb_mipi_rx_raw_unpack;

   logic        clk_i = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  mode_i = 2'b00;
   logic        sol_i = 1'b0;
   logic        in_valid_i = 1'b0;
   logic        in_ready_o;
   logic [31:0] in_data_i = '0;
   logic        in_eol_i = 1'b0;
   logic        out_valid_o;
   logic        out_ready_i = 1'b0;
   logic [47:0] out_pix_o;
   logic        err_residual_o;
   logic        cfg_err_o;

   int checks = 0;
   int errors = 0;

   mipi_rx_raw_unpack #(
      .LANES     (4),
      .PIX_W     (12),
      .BUF_BYTES (16)
   ) dut (
      .clk_i          (clk_i),
      .reset_n        (reset_n),
      .mode_i         (mode_i),
      .sol_i          (sol_i),
      .in_valid_i     (in_valid_i),
      .in_ready_o     (in_ready_o),
      .in_data_i      (in_data_i),
      .in_eol_i       (in_eol_i),
      .out_valid_o    (out_valid_o),
      .out_ready_i    (out_ready_i),
      .out_pix_o      (out_pix_o),
      .err_residual_o (err_residual_o),
      .cfg_err_o      (cfg_err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   function automatic logic [47:0] raw10_ref(input logic [7:0] b0, input logic [7:0] b1,
                                             input logic [7:0] b2, input logic [7:0] b3,
                                             input logic [7:0] b4);
      return {2'b00, b3, b4[7:6], 2'b00, b2, b4[5:4], 2'b00, b1, b4[3:2], 2'b00, b0, b4[1:0]};
   endfunction

   task automatic start_line(input logic [1:0] m);
      mode_i = m;
      sol_i  = 1'b1;
      step();
      sol_i  = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if ({out_valid_o, in_ready_o, err_residual_o, cfg_err_o, out_pix_o} !== '0) begin
         $display("FAIL reset_state got %b/%b/%b/%b pix %h want all 0",
                  out_valid_o, in_ready_o, err_residual_o, cfg_err_o, out_pix_o);
         errors++;
      end
      @(negedge clk_i);
      reset_n = 1'b1;
      step();
      checks++;
      if (in_ready_o !== 1'b0) begin
         $display("FAIL idle_not_ready got %b want 0", in_ready_o);
         errors++;
      end
   endtask

   task automatic test_raw8();
      int errp = 0;
      out_ready_i = 1'b1;
      start_line(2'b00);
      checks++;
      if (in_ready_o !== 1'b1) begin
         $display("FAIL raw8_ready got %b want 1", in_ready_o);
         errors++;
      end
      in_valid_i = 1'b1;
      in_data_i  = 32'h44332211;
      in_eol_i   = 1'b1;
      step();
      in_valid_i = 1'b0;
      in_eol_i   = 1'b0;
      checks++;
      if (out_valid_o !== 1'b1 || out_pix_o !== {12'h044, 12'h033, 12'h022, 12'h011}) begin
         $display("FAIL raw8_pix got v=%b %h want v=1 044033022011", out_valid_o, out_pix_o);
         errors++;
      end
      for (int i = 0; i < 4; i++) begin
         step();
         if (err_residual_o) errp++;
      end
      checks++;
      if (out_valid_o !== 1'b0 || errp != 0) begin
         $display("FAIL raw8_done got v=%b err_pulses=%0d want v=0 0", out_valid_o, errp);
         errors++;
      end
   endtask

   task automatic test_raw10_residual();
      int errp = 0;
      out_ready_i = 1'b1;
      start_line(2'b01);
      in_valid_i = 1'b1;
      in_data_i  = 32'h44332211;
      step();
      checks++;
      if (out_valid_o !== 1'b0) begin
         $display("FAIL raw10_early got v=%b want 0", out_valid_o);
         errors++;
      end
      in_data_i = 32'hCCBBAAE4;
      in_eol_i  = 1'b1;
      step();
      in_valid_i = 1'b0;
      in_eol_i   = 1'b0;
      checks++;
      if (out_valid_o !== 1'b1 || out_pix_o !== {12'h113, 12'h0CE, 12'h089, 12'h044}) begin
         $display("FAIL raw10_pix got v=%b %h want v=1 1130ce089044", out_valid_o, out_pix_o);
         errors++;
      end
      for (int i = 0; i < 6; i++) begin
         step();
         if (err_residual_o) errp++;
      end
      checks++;
      if (errp != 1) begin
         $display("FAIL raw10_residual got %0d pulses want 1", errp);
         errors++;
      end
   endtask

   task automatic test_raw12();
      out_ready_i = 1'b1;
      start_line(2'b10);
      in_valid_i = 1'b1;
      in_data_i  = 32'hAB21CDAB;
      step();
      in_data_i = 32'h000021CD;
      in_eol_i  = 1'b1;
      step();
      in_valid_i = 1'b0;
      in_eol_i   = 1'b0;
      checks++;
      if (out_valid_o !== 1'b1 || out_pix_o !== {12'hCD2, 12'hAB1, 12'hCD2, 12'hAB1}) begin
         $display("FAIL raw12_pix got v=%b %h want v=1 cd2ab1cd2ab1", out_valid_o, out_pix_o);
         errors++;
      end
      for (int i = 0; i < 4; i++) step();
   endtask

   task automatic test_backpressure();
      int bi = 0;
      int got = 0;
      int errp = 0;
      int stable_bad = 0;
      bit saw_full = 1'b0;
      bit have_held = 1'b0;
      bit acc;
      logic [47:0] held = '0;
      logic [47:0] exp_pix;
      out_ready_i = 1'b0;
      start_line(2'b01);
      for (int cyc = 0; cyc < 300 && got < 8; cyc++) begin
         if (bi < 10) begin
            in_valid_i = 1'b1;
            for (int j = 0; j < 4; j++) in_data_i[8*j +: 8] = 8'(4*bi + j);
            in_eol_i = (bi == 9);
         end else begin
            in_valid_i = 1'b0;
            in_eol_i   = 1'b0;
         end
         out_ready_i = (cyc >= 12);
         if (!in_ready_o && cyc < 12) saw_full = 1'b1;
         if (out_valid_o && !out_ready_i) begin
            if (have_held && out_pix_o !== held) stable_bad++;
            held      = out_pix_o;
            have_held = 1'b1;
         end
         acc = in_valid_i && in_ready_o;
         if (out_valid_o && out_ready_i) begin
            exp_pix = raw10_ref(8'(5*got), 8'(5*got+1), 8'(5*got+2), 8'(5*got+3), 8'(5*got+4));
            checks++;
            if (out_pix_o !== exp_pix) begin
               $display("FAIL bp_group%0d got %h want %h", got, out_pix_o, exp_pix);
               errors++;
            end
            got++;
         end
         if (err_residual_o) errp++;
         step();
         if (acc) bi++;
      end
      in_valid_i = 1'b0;
      in_eol_i   = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (err_residual_o) errp++;
      end
      checks++;
      if (!saw_full) begin
         $display("FAIL bp_ready_fall got in_ready never 0 want 0 while stalled");
         errors++;
      end
      checks++;
      if (stable_bad != 0) begin
         $display("FAIL bp_stable got %0d changes want 0", stable_bad);
         errors++;
      end
      checks++;
      if (got != 8 || errp != 0) begin
         $display("FAIL bp_count got groups=%0d err=%0d want 8 0", got, errp);
         errors++;
      end
   endtask

   task automatic test_sol_midline();
      int errp = 0;
      out_ready_i = 1'b1;
      start_line(2'b01);
      in_valid_i = 1'b1;
      in_data_i  = 32'h03020100;
      step();
      in_data_i = 32'h07060504;
      step();
      checks++;
      if (out_valid_o !== 1'b1 || out_pix_o !== {12'h00C, 12'h008, 12'h005, 12'h000}) begin
         $display("FAIL sol_old_group got v=%b %h want v=1 00c008005000", out_valid_o, out_pix_o);
         errors++;
      end
      mode_i    = 2'b00;
      sol_i     = 1'b1;
      in_data_i = 32'hD4C3B2A1;
      step();
      sol_i      = 1'b0;
      in_valid_i = 1'b0;
      if (err_residual_o) errp++;
      checks++;
      if (out_valid_o !== 1'b1 || out_pix_o !== {12'h0D4, 12'h0C3, 12'h0B2, 12'h0A1}) begin
         $display("FAIL sol_new_group got v=%b %h want v=1 0d40c30b20a1", out_valid_o, out_pix_o);
         errors++;
      end
      for (int i = 0; i < 4; i++) begin
         step();
         if (err_residual_o) errp++;
      end
      checks++;
      if (errp != 0 || out_valid_o !== 1'b0) begin
         $display("FAIL sol_no_residual got err=%0d v=%b want 0 0", errp, out_valid_o);
         errors++;
      end
   endtask

   task automatic test_cfg_err();
      out_ready_i = 1'b1;
      start_line(2'b11);
      checks++;
      if (cfg_err_o !== 1'b1) begin
         $display("FAIL cfg_err_set got %b want 1", cfg_err_o);
         errors++;
      end
      in_valid_i = 1'b1;
      in_data_i  = 32'h8877_6655;
      step();
      in_valid_i = 1'b0;
      checks++;
      if (out_pix_o !== {12'h088, 12'h077, 12'h066, 12'h055}) begin
         $display("FAIL cfg_raw8 got %h want 088077066055", out_pix_o);
         errors++;
      end
      start_line(2'b00);
      checks++;
      if (cfg_err_o !== 1'b1) begin
         $display("FAIL cfg_err_sticky got %b want 1", cfg_err_o);
         errors++;
      end
   endtask

   task automatic test_async_reset();
      out_ready_i = 1'b0;
      in_valid_i  = 1'b1;
      in_data_i   = 32'h01020304;
      step();
      in_valid_i = 1'b0;
      checks++;
      if (out_valid_o !== 1'b1) begin
         $display("FAIL arst_pre got v=%b want 1", out_valid_o);
         errors++;
      end
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if ({out_valid_o, in_ready_o, err_residual_o, cfg_err_o} !== 4'b0000) begin
         $display("FAIL arst_clear got %b%b%b%b want 0000",
                  out_valid_o, in_ready_o, err_residual_o, cfg_err_o);
         errors++;
      end
      @(negedge clk_i);
      reset_n = 1'b1;
      step();
      checks++;
      if (in_ready_o !== 1'b0 || out_valid_o !== 1'b0) begin
         $display("FAIL arst_release got rdy=%b v=%b want 0 0", in_ready_o, out_valid_o);
         errors++;
      end
   endtask

   initial begin
      test_reset();
      test_raw8();
      test_raw10_residual();
      test_raw12();
      test_backpressure();
      test_sol_midline();
      test_cfg_err();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
